// File: rtl/manchester_tx_stream_pkg.sv
// Shared types and helpers for the Manchester line encoder.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package manch_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_H1, ST_H2} manch_st_t;

    // Line level for one half of a symbol. With pol=0 a 0 bit is high->low
    // and a 1 bit is low->high; pol=1 inverts both halves.
    function automatic bit manch_level(bit b, bit half, bit pol);
        return ~(b ^ half) ^ pol;
    endfunction

endpackage

// File: rtl/manchester_tx_stream_if.sv
// Word handshake plus serial line outputs of the Manchester encoder.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the encoder gates in_valid from the source.
interface manchester_tx_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_out;
    logic              tx_active;
    logic              frame_done;

    // Word source side
    modport master (
        output in_data, in_valid,
        input  in_ready, tx_out, tx_active, frame_done
    );

    // Encoder side
    modport slave (
        input  in_data, in_valid,
        output in_ready, tx_out, tx_active, frame_done
    );
endinterface

// File: rtl/manchester_tx_stream_half_tick.sv
// Half-bit timer: loadable down-counter flagging the last clock of each half-bit.
// Latency: o_tc is high in the HALF_CYC-th clock after a load.
// Backpressure: none; it holds at its terminal value until reloaded, never wraps.
module manch_half_tick #(
    parameter int HALF_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(HALF_CYC + 1);

    logic [CW-1:0] r_cnt;

    // Count clocks remaining in the current half-bit, reloading at each half start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CW'(HALF_CYC);
        end else if (i_load) begin
            r_cnt <= CW'(HALF_CYC);
        end else if (i_en && (r_cnt > CW'(1))) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == CW'(1));
endmodule

// File: rtl/manchester_tx_stream.sv
// Manchester encoder: serialises DATA_W-bit words, optional preamble under MANCH_PREAMBLE_EN.
// Latency: first half-bit on tx_out 1 clock after accept; frame = 2*HALF_CYC*(DATA_W[+PRE_LEN]) clk.
// Backpressure: in_ready only in IDLE and the last clock of the last data half-bit (gapless streaming).
module manchester_tx_stream
    import manch_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int HALF_CYC  = 4,
    parameter bit POLARITY  = 1'b0,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b0,
    parameter int PRE_LEN   = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    manchester_tx_stream_if.slave s_if
);
    localparam int BW = $clog2(DATA_W + 1);

    manch_st_t         r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [BW-1:0]     r_bit_cnt, w_bit_cnt_nxt;
    logic              r_tx_out, r_tx_active;
    logic              w_tx_nxt, w_cur_bit_nxt;
    logic              w_load, w_tc, w_ready, w_start, w_frame_done, w_last_bit;

`ifdef MANCH_PREAMBLE_EN
    localparam int PW = $clog2(PRE_LEN + 1);

    logic [PW-1:0] r_pre_cnt, w_pre_cnt_nxt;
    logic          r_pre_half, w_pre_half_nxt;
    logic          r_pre_bit, w_pre_bit_nxt;
`endif

    manch_half_tick #(
        .HALF_CYC (HALF_CYC)
    ) u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (r_state != ST_IDLE),
        .o_tc   (w_tc)
    );

    assign w_last_bit = (r_bit_cnt == BW'(1));

    // Next-state, handshake and datapath updates; w_start loads a fresh word
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_load        = 1'b0;
        w_ready       = 1'b0;
        w_start       = 1'b0;
        w_frame_done  = 1'b0;
`ifdef MANCH_PREAMBLE_EN
        w_pre_cnt_nxt  = r_pre_cnt;
        w_pre_half_nxt = r_pre_half;
        w_pre_bit_nxt  = r_pre_bit;
`endif
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                w_start = s_if.in_valid;
            end
`ifdef MANCH_PREAMBLE_EN
            ST_PRE: begin
                if (w_tc) begin
                    w_load = 1'b1;
                    if (!r_pre_half) begin
                        w_pre_half_nxt = 1'b1;
                    end else begin
                        w_pre_half_nxt = 1'b0;
                        w_pre_bit_nxt  = ~r_pre_bit;
                        if (r_pre_cnt == PW'(1)) begin
                            w_state_nxt = ST_H1;
                        end else begin
                            w_pre_cnt_nxt = r_pre_cnt - 1'b1;
                        end
                    end
                end
            end
`endif
            ST_H1: begin
                if (w_tc) begin
                    w_state_nxt = ST_H2;
                    w_load      = 1'b1;
                end
            end
            ST_H2: begin
                if (w_tc) begin
                    if (!w_last_bit) begin
                        w_state_nxt   = ST_H1;
                        w_shift_nxt   = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
                        w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                        w_load        = 1'b1;
                    end else begin
                        // Stream slot: a word accepted here follows with no gap
                        w_ready       = 1'b1;
                        w_frame_done  = 1'b1;
                        w_start       = s_if.in_valid;
                        w_state_nxt   = ST_IDLE;
                        w_bit_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_shift_nxt   = s_if.in_data;
            w_bit_cnt_nxt = BW'(DATA_W);
            w_load        = 1'b1;
`ifdef MANCH_PREAMBLE_EN
            w_state_nxt    = ST_PRE;
            w_pre_cnt_nxt  = PW'(PRE_LEN);
            w_pre_half_nxt = 1'b0;
            w_pre_bit_nxt  = 1'b1;
`else
            w_state_nxt    = ST_H1;
`endif
        end
    end

    assign w_cur_bit_nxt = MSB_FIRST ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];

    // Line level for the coming clock, so tx_out is a flop aligned with the state
    always_comb begin
        w_tx_nxt = IDLE_LVL;
        case (w_state_nxt)
`ifdef MANCH_PREAMBLE_EN
            ST_PRE:  w_tx_nxt = manch_level(w_pre_bit_nxt, w_pre_half_nxt, POLARITY);
`endif
            ST_H1:   w_tx_nxt = manch_level(w_cur_bit_nxt, 1'b0, POLARITY);
            ST_H2:   w_tx_nxt = manch_level(w_cur_bit_nxt, 1'b1, POLARITY);
            default: w_tx_nxt = IDLE_LVL;
        endcase
    end

    // State, word shift register, bit counter and registered line outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tx_out    <= IDLE_LVL;
            r_tx_active <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_tx_out    <= w_tx_nxt;
            r_tx_active <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef MANCH_PREAMBLE_EN
    // Preamble bit counter, half flag and alternating bit value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt  <= '0;
            r_pre_half <= 1'b0;
            r_pre_bit  <= 1'b1;
        end else begin
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_pre_half <= w_pre_half_nxt;
            r_pre_bit  <= w_pre_bit_nxt;
        end
    end
`endif

    // Ready is forced low while reset is held, high in the first clock after release
    assign s_if.in_ready   = w_ready & rst_n;
    assign s_if.tx_out     = r_tx_out;
    assign s_if.tx_active  = r_tx_active;
    assign s_if.frame_done = w_frame_done;
endmodule
